// File: rtl/sigma_delta_adc_sequencer_if.sv
// sigma_delta_adc_sequencer_if: tagged sample stream from the sequencer to its consumer
interface sigma_delta_adc_sequencer_if #(
  parameter int NCH  = 4,
  parameter int WDTH = 16
);
  logic [WDTH-1:0]        m_data;
  logic [$clog2(NCH)-1:0] m_chan;
  logic                   m_valid;
  logic                   m_ready;
  modport master (output m_data, m_chan, m_valid, input m_ready);
  modport slave  (input m_data, m_chan, m_valid, output m_ready);
endinterface

// File: rtl/sigma_delta_adc_sequencer.sv
// sigma_delta_adc_sequencer: settles, buffers and round-robin merges multi-channel ADC samples
module sigma_delta_adc_sequencer #(
  parameter int NCH    = 4,
  parameter int WDTH   = 16,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NCH-1:0]           ch_mask,
  input  logic [NCH*WDTH-1:0]      adc_output,
  input  logic [NCH-1:0]           adc_valid,
  output logic [NCH-1:0]           overrun,
  input  logic                     clear_overrun,
  output logic                     busy,
  sigma_delta_adc_sequencer_if.master m
);
  localparam int PW = $clog2(NCH);
  localparam int CW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [NCH-1:0]  mask_q, mask_d, full_q, full_d, ovr_q, ovr_d;
  logic [CW-1:0]   cnt_q [NCH];
  logic [CW-1:0]   cnt_d [NCH];
  logic [WDTH-1:0] hold_q [NCH];
  logic [WDTH-1:0] hold_d [NCH];
  logic [WDTH-1:0] m_data_q, m_data_d;
  logic [PW-1:0]   m_chan_q, m_chan_d, rr_q, rr_d, gnt, idx;
  logic            m_valid_q, m_valid_d, busy_q, found, load, gv, run, start;
  logic [NCH-1:0]  settled, hit;

  assign run   = state_q == RUN;
  assign start = state_q == IDLE && enable;
  assign load  = !m_valid_q || m.m_ready;
  assign gv    = load && found;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign settled[c] = cnt_q[c] == CW'(SETTLE);
    assign hit[c]     = run & adc_valid[c] & mask_q[c];
  end

  assign state_d = start ? RUN :
                   (run && !enable) ? DRAIN :
                   (state_q == DRAIN && full_q == '0 && !m_valid_q) ? IDLE : state_q;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = PW'((int'(rr_q) + k) % NCH);
      if (!found && full_q[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  // a grant frees the buffer in the same cycle, so a coincident capture is not an overrun
  always_comb begin
    mask_d = start ? ch_mask : mask_q;
    full_d = full_q;
    ovr_d  = clear_overrun ? '0 : ovr_q;
    hold_d = hold_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (start) cnt_d[i] = '0;
      else if (hit[i] && !settled[i]) cnt_d[i] = cnt_q[i] + 1'b1;
      if (gv && gnt == PW'(i)) full_d[i] = 1'b0;
      if (hit[i] && settled[i]) begin
        if (!full_q[i] || (gv && gnt == PW'(i))) begin
          full_d[i] = 1'b1;
          hold_d[i] = adc_output[i*WDTH +: WDTH];
        end else ovr_d[i] = 1'b1;
      end
    end
  end

  assign m_data_d  = gv ? hold_q[gnt] : m_data_q;
  assign m_chan_d  = gv ? gnt : m_chan_q;
  assign m_valid_d = load ? found : m_valid_q;
  assign rr_d      = gv ? (gnt == PW'(NCH - 1) ? '0 : gnt + 1'b1) : rr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      full_q    <= '0;
      ovr_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_chan_q  <= '0;
      rr_q      <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      full_q    <= full_d;
      ovr_q     <= ovr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_chan_q  <= m_chan_d;
      rr_q      <= rr_d;
      busy_q    <= state_d != IDLE;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
    end
  end

  assign m.m_data  = m_data_q;
  assign m.m_chan  = m_chan_q;
  assign m.m_valid = m_valid_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;
endmodule

// File: doc/sigma_delta_adc_sequencer.md
# sigma_delta_adc_sequencer

Multi-channel capture controller for `sigma_delta_adc` instances. It gates each channel's decimated output stream, discards the first `SETTLE` samples after every start while the CIC comb stages settle, and buffers one sample per channel. A round-robin arbiter merges the channels onto a single valid/ready output tagged with the channel number. Overruns are reported per channel. The block sits between the ADC channel array and the sample consumer (FIFO, DMA or serial link).

## Interface

Clocking: one clock; reset is synchronous and active-high.

Parameters:
- `NCH` — default 4 — number of ADC channels, ≥2.
- `WDTH` — default 16 — sample width; matches the ADC `WDTH`.
- `SETTLE` — default 2 — samples discarded per channel after entering RUN; 0 disables discard.

Ports:
- `clk` — in — 1 — system clock; same clock as the ADCs.
- `rst` — in — 1 — synchronous, active-high reset.
- `enable` — in — 1 — level; high requests capture.
- `ch_mask` — in — NCH — channel enables; sampled on the IDLE→RUN transition.
- `adc_output` — in — NCH*WDTH — channel i at `[i*WDTH +: WDTH]`.
- `adc_valid` — in — NCH — one-cycle sample strobes, channel i at bit i.
- `m_data` — out — WDTH — output sample.
- `m_chan` — out — $clog2(NCH) — channel of `m_data`.
- `m_valid` — out — 1 — output valid.
- `m_ready` — in — 1 — consumer ready.
- `overrun` — out — NCH — sticky per-channel sample-drop flags.
- `clear_overrun` — in — 1 — clears all `overrun` bits.
- `busy` — out — 1 — high when state ≠ IDLE.

## Operation

- **States:** IDLE, RUN, DRAIN.
  - IDLE→RUN when `enable`=1. Same edge: `mask_q`←`ch_mask`, all settle counters←0.
  - RUN→DRAIN when `enable`=0.
  - DRAIN→IDLE when all hold buffers are empty and `m_valid`=0.
  - `enable` during DRAIN is ignored. The block re-enters RUN from IDLE on the next cycle if `enable` is still high.
- **Settle counter:** per channel, width $clog2(SETTLE+1). In RUN, `adc_valid[i] & mask_q[i]` increments the counter while it is below `SETTLE`; those samples are discarded. Channel i is settled when its counter equals `SETTLE`.
- **Capture:** in RUN only, when `adc_valid[i] & mask_q[i] & settled[i]`:
  - hold[i]←sample, full[i]←1.
  - If full[i]=1 and hold[i] is not being granted in the same cycle, the new sample is dropped and `overrun[i]`←1.
  - Grant and capture in the same cycle: capture succeeds, no overrun.
  - No captures in IDLE or DRAIN.
- **Output register load:** when `m_valid`=0 or (`m_valid` & `m_ready`).
  - If any full[i] is set: grant the first full channel searching from `rr_ptr` upward modulo NCH. Load `m_data`/`m_chan`, set `m_valid`, clear full[g], set `rr_ptr`←(g+1) mod NCH.
  - If no full[i] is set: `m_valid`←0.
- **Hold rule:** while `m_valid`=1 and `m_ready`=0, `m_data`/`m_chan` are stable. `m_valid` never drops without a handshake.
- **`overrun`:** set has priority over `clear_overrun` in the same cycle. Not cleared by state changes.
- **Masked-off channels:** never settle, capture or overrun.
- **Reset:** state IDLE; `m_valid`, `m_data`, `m_chan`, `overrun`, `busy`, full[], `mask_q`, settle counters and `rr_ptr` all 0.
  - Reset mid-RUN discards buffered and output data immediately; the handshake is abandoned.

## Timing

- Capture latency: `adc_valid[i]` in cycle t → full[i] in t+1 → `m_valid` with the sample in t+2, provided the output register is free and channel i wins arbitration.
- Throughput: one sample per cycle with `m_ready` held high.
- `busy` is registered and tracks the state. It rises the cycle after `enable` is sampled high in IDLE.
- Arbitration fairness: a full channel is granted within NCH output handshakes.
- All outputs are registered; there is no combinational path from `m_ready` to `m_valid`/`m_data`.

## Test plan

- **Settle discard:** `SETTLE`=2, `ch_mask`=4'b0001, `enable`=1, channel 0 strobes values 10, 11, 12, 13 with `m_ready`=1 → output is exactly 12 then 13, `m_chan`=0. The first 12 appears 2 cycles after its strobe.
- **Round-robin:** all 4 channels strobe together after settling, values 100+i, `m_ready`=1 → outputs in order ch0, ch1, ch2, ch3 on consecutive cycles. A second simultaneous burst also comes out ch0..ch3, since `rr_ptr` wrapped back to 0.
- **Back-pressure/overrun:** `m_ready`=0, channel 1 strobes 5 three times → `m_data`=5 on ch1 stays stable, the hold buffer keeps the second 5, the third sample is dropped and `overrun`=4'b0010. Pulsing `clear_overrun` → `overrun`=0.
- **Simultaneous grant and capture:** hold[2] full, output free, channel 2 strobes again in the same cycle → no overrun, and both samples are emitted in order.
- **Drain:** hold buffers for ch0 and ch3 full with `m_ready`=0, drop `enable` → `busy` stays 1 and new strobes are ignored. Release `m_ready` → both samples are emitted, then state returns to IDLE and `busy`=0.
- **Reset mid-run:** assert `rst` with `m_valid`=1 → next cycle `m_valid`=0, `overrun`=0, `busy`=0. Re-enable with a new `ch_mask` → the new mask applies and settle discard restarts.
